generate_6_bit_sequence_using_fsm: RTL and testbench

//  Serial pattern transmitter: the driving end of the serial sequence-detector link.

---
 rtl/generate_6_bit_sequence_using_fsm.sv | 116 +++++++++++
 tb/tb_generate_6_bit_sequence_using_fsm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/generate_6_bit_sequence_using_fsm.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first, reps times, GAP_CYCLES idle between repeats.
// Latency: first bit one cycle after accept. No backpressure: start is taken only while ready=1, abort cancels an active transfer.
module generate_6_bit_sequence_using_fsm #(
  parameter int WIDTH      = 6,
  parameter int GAP_CYCLES = 2,
  parameter int REPS_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [REPS_W-1:0] reps,
  input  logic              abort,
  output logic              ready,
  output logic              out,
  output logic              out_valid,
  output logic              done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0]     BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0]     GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [REPS_W-1:0] REP_ONE  = REPS_W'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  shift_reg;
  logic [WIDTH-1:0]  pat_reg;
  logic [BW-1:0]     bit_cnt;
  logic [REPS_W-1:0] rep_cnt;
  logic [GW-1:0]     gap_cnt;

  // shift_reg is cleared whenever SEND is left, so its MSB is already 0 when out_valid=0
  assign ready     = (state == IDLE);
  assign out_valid = (state == SEND);
  assign done      = (state == DONE);
  assign out       = shift_reg[WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      pat_reg   <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pat_reg <= pattern;
            rep_cnt <= reps;
            bit_cnt <= '0;
            gap_cnt <= '0;
            if (reps != '0) begin
              shift_reg <= pattern;
              state     <= SEND;
            end else begin
              state     <= DONE;
            end
          end
        end

        SEND: begin
          if (abort) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
          end else if (bit_cnt == BIT_LAST) begin
            rep_cnt <= rep_cnt - REP_ONE;
            bit_cnt <= '0;
            if (rep_cnt == REP_ONE) begin
              state     <= DONE;
              shift_reg <= '0;
            end else if (GAP_CYCLES == 0) begin
              shift_reg <= pat_reg;
            end else begin
              state     <= GAP;
              shift_reg <= '0;
              gap_cnt   <= '0;
            end
          end else begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + BW'(1);
          end
        end

        GAP: begin
          if (abort) begin
            state   <= IDLE;
            rep_cnt <= '0;
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            state     <= SEND;
            shift_reg <= pat_reg;
            gap_cnt   <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generate_6_bit_sequence_using_fsm.sv
// Bench for the serial pattern transmitter: per-cycle comparison against a queue of expected cycles built from the pattern/reps rules.
module tb_generate_6_bit_sequence_using_fsm;
  localparam int W  = 6;
  localparam int G  = 2;
  localparam int RW = 4;

  localparam logic [1:0] K_BIT  = 2'd0;
  localparam logic [1:0] K_GAP  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  pattern = '0;
  logic [RW-1:0] reps = '0;
  logic          ready, out, out_valid, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] kind;
    logic       b;
  } ent_t;

  ent_t exp_q[$];

  generate_6_bit_sequence_using_fsm #(.WIDTH(W), .GAP_CYCLES(G), .REPS_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps), .abort(abort),
    .ready(ready), .out(out), .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b (ready,out_valid,out,done)", tag, got[3:0], want[3:0]);
    end
  endtask

  // Expected {ready,out_valid,out,done} for the current cycle.
  function automatic logic [3:0] exp_vec();
    if (exp_q.size() == 0) return 4'b1000;
    case (exp_q[0].kind)
      K_BIT:   return {2'b01, exp_q[0].b, 1'b0};
      K_DONE:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Transfer as a cycle list: WIDTH bits per repeat MSB-first, G idle cycles between repeats, one done cycle.
  task automatic load(input logic [W-1:0] p, input int r);
    ent_t e;
    exp_q.delete();
    for (int i = 0; i < r; i++) begin
      for (int j = W - 1; j >= 0; j--) begin
        e.kind = K_BIT; e.b = p[j]; exp_q.push_back(e);
      end
      if (i < r - 1) begin
        for (int g = 0; g < G; g++) begin
          e.kind = K_GAP; e.b = 1'b0; exp_q.push_back(e);
        end
      end
    end
    e.kind = K_DONE; e.b = 1'b0; exp_q.push_back(e);
  endtask

  // Called at a falling edge: check this cycle, drive inputs, advance the model across the next rising edge.
  task automatic step(input logic s, input logic [W-1:0] p, input logic [RW-1:0] r, input logic a, input string tag);
    chk(tag, {28'd0, ready, out_valid, out, done}, {28'd0, exp_vec()});
    start = s; pattern = p; reps = r; abort = a;
    if (exp_q.size() == 0) begin
      if (s) load(p, int'(r));
    end else if (a && exp_q[0].kind != K_DONE) begin
      exp_q.delete();
    end else begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, tag);
  endtask

  initial begin
    logic s, a;
    logic [W-1:0] p;
    logic [RW-1:0] r;

    #1 rst = 1'b0;
    #10;
    chk("reset_state", {28'd0, ready, out_valid, out, done}, 32'b1000);
    @(negedge clk);
    rst = 1'b1;

    // single repeat of 110011
    step(1'b1, 6'b110011, 4'd1, 1'b0, "t1_accept");
    idle_steps(9, "t1_stream");

    // zero repeats: done only
    step(1'b1, 6'b101010, 4'd0, 1'b0, "t3_accept");
    idle_steps(3, "t3_zero_reps");

    // start during SEND with another pattern must be ignored
    step(1'b1, 6'b100101, 4'd2, 1'b0, "t4_accept");
    idle_steps(2, "t4_stream");
    step(1'b1, 6'b011010, 4'd5, 1'b0, "t4_ignored_start");
    idle_steps(14, "t4_stream");

    // abort on 3rd bit of repeat 2 of 3, then a new start
    step(1'b1, 6'b111000, 4'd3, 1'b0, "t5_accept");
    idle_steps(10, "t5_stream");
    step(1'b0, '0, '0, 1'b1, "t5_abort");
    step(1'b0, '0, '0, 1'b0, "t5_after_abort");
    step(1'b1, 6'b010110, 4'd1, 1'b1, "t5_start_beats_abort");
    idle_steps(9, "t5_restart");

    // async reset mid-GAP
    step(1'b1, 6'b101101, 4'd2, 1'b0, "t6_accept");
    idle_steps(6, "t6_stream");
    chk("t6_in_gap", {28'd0, ready, out_valid, out, done}, {28'd0, exp_vec()});
    rst = 1'b0;
    #1;
    chk("t6_async_reset", {28'd0, ready, out_valid, out, done}, 32'b1000);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 6'b110001, 4'd1, 1'b0, "t6_clean_accept");
    idle_steps(8, "t6_clean");

    // maximum repeat count
    step(1'b1, 6'b100011, 4'd15, 1'b0, "max_accept");
    idle_steps(6 * 15 + 2 * 14 + 3, "max_stream");

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      p = W'($urandom);
      if (exp_q.size() == 0) begin
        s = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 9) == 0) ? 4'd15 : RW'($urandom_range(0, 4));
        a = ($urandom_range(0, 9) == 0);
      end else begin
        s = ($urandom_range(0, 3) == 0);
        r = RW'($urandom);
        a = ($urandom_range(0, 39) == 0);
      end
      step(s, p, r, a, "random");
    end
    idle_steps(2, "random_tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
